// File: rtl/ysyx_23060236_lsu_pkg.sv
// ysyx_23060236_lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32 load/store funct3 codes and the access-size field funct3[1:0]
//   - 3-bit LSU state encodings
//   - AXI response code for OKAY
//   - lsu_misaligned(): alignment rule shared by the FSM and the lane aligner
package ysyx_23060236_lsu_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // funct3[1:0] doubles as the AXI size code
  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

  localparam logic [2:0] LSU_IDLE = 3'd0;
  localparam logic [2:0] LSU_AR   = 3'd1;
  localparam logic [2:0] LSU_R    = 3'd2;
  localparam logic [2:0] LSU_AWW  = 3'd3;
  localparam logic [2:0] LSU_B    = 3'd4;
  localparam logic [2:0] LSU_RESP = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      LSU_SIZE_HALF: return addr_lo[0];
      LSU_SIZE_WORD: return (addr_lo != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060236_Reg.sv
// ysyx_23060236_Reg
// Generic enabled register with synchronous active-high reset.
//   clock, reset : clock and synchronous reset
//   din, wen     : next value and load enable
//   dout         : registered value (RESET_VAL after reset)
module ysyx_23060236_Reg #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clock) begin
    if (reset) dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_23060236_lsu_align.sv
// ysyx_23060236_lsu_align
// Combinational byte-lane steering for the LSU.
//   funct3, addr_lo : access type and low address bits of the latched request
//   wdata           : LSB-aligned store data
//   rdata           : raw 32-bit read data from the bus
//   wstrb           : byte strobes placed on the addressed lanes
//   wdata_shifted   : store data moved onto the addressed lanes
//   rdata_ext       : addressed lanes moved to the LSB, sign/zero extended
//   misaligned      : access violates natural alignment
module ysyx_23060236_lsu_align
  import ysyx_23060236_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_shifted,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [4:0]  shamt;
  logic [31:0] raw;
  logic [3:0]  size_mask;
  logic        sign_en;

  assign shamt         = {addr_lo, 3'b000};
  assign raw           = rdata >> shamt;
  // funct3[2] selects the unsigned variants (LBU/LHU)
  assign sign_en       = ~funct3[2];
  assign wstrb         = size_mask << addr_lo;
  assign wdata_shifted = wdata << shamt;
  assign misaligned    = lsu_misaligned(funct3[1:0], addr_lo);

  always_comb begin
    size_mask = 4'b1111;
    rdata_ext = raw;
    case (funct3[1:0])
      LSU_SIZE_BYTE: begin
        size_mask = 4'b0001;
        rdata_ext = {{24{raw[7] & sign_en}}, raw[7:0]};
      end
      LSU_SIZE_HALF: begin
        size_mask = 4'b0011;
        rdata_ext = {{16{raw[15] & sign_en}}, raw[15:0]};
      end
      default: begin
        size_mask = 4'b1111;
        rdata_ext = raw;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060236_lsu.sv
// ysyx_23060236_lsu
// Load/store bus master: turns one core load/store at a time into a
// single-beat AXI4-Lite-style transaction on the xbar lsu_* channels.
//   clock, reset                  : clock, synchronous active-high reset
//   req_*                         : core request (valid/ready handshake)
//   resp_valid/resp_rdata/resp_err: one-cycle completion, extended load data, error
//   lsu_ar*/lsu_r*                : read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b*         : write address / write data / write response channels
module ysyx_23060236_lsu
  import ysyx_23060236_lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,

  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,

  output logic [31:0] lsu_araddr,
  output logic        lsu_arvalid,
  output logic [2:0]  lsu_arsize,
  input  logic        lsu_arready,

  input  logic [31:0] lsu_rdata,
  input  logic [1:0]  lsu_rresp,
  input  logic        lsu_rvalid,
  output logic        lsu_rready,

  output logic [31:0] lsu_awaddr,
  output logic        lsu_awvalid,
  output logic [2:0]  lsu_awsize,
  input  logic        lsu_awready,

  output logic [31:0] lsu_wdata,
  output logic [3:0]  lsu_wstrb,
  output logic        lsu_wvalid,
  input  logic        lsu_wready,

  input  logic [1:0]  lsu_bresp,
  input  logic        lsu_bvalid,
  output logic        lsu_bready
);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic        wen_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q;
  logic        err_q, err_d, err_wen;

  logic        accept;
  logic        req_misaligned;
  logic        aw_fire, w_fire, aww_finish;
  logic        r_fire, b_fire, rdata_wen;
  logic [3:0]  strb_lanes;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_ext;
  logic        latched_misaligned;

  assign accept         = (state_q == LSU_IDLE) && req_valid;
  assign req_misaligned = lsu_misaligned(req_funct3[1:0], req_addr[1:0]);

  assign aw_fire    = lsu_awvalid && lsu_awready;
  assign w_fire     = lsu_wvalid && lsu_wready;
  // Covers both "finished on earlier cycles" and "both handshake together".
  assign aww_finish = (aw_done_q || aw_fire) && (w_done_q || w_fire);
  assign r_fire     = lsu_rvalid && lsu_rready;
  assign b_fire     = lsu_bvalid && lsu_bready;

  ysyx_23060236_lsu_align u_align (
    .funct3        (funct3_q),
    .addr_lo       (addr_q[1:0]),
    .wdata         (wdata_q),
    .rdata         (lsu_rdata),
    .wstrb         (strb_lanes),
    .wdata_shifted (wdata_lanes),
    .rdata_ext     (rdata_ext),
    .misaligned    (latched_misaligned)
  );

  // Next-state logic; bus handshakes are only honoured in their own state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          if (req_misaligned) state_d = LSU_RESP;
          else if (req_wen)   state_d = LSU_AWW;
          else                state_d = LSU_AR;
        end
      end
      LSU_AR:   if (lsu_arvalid && lsu_arready) state_d = LSU_R;
      LSU_R:    if (r_fire) state_d = LSU_RESP;
      LSU_AWW:  if (aww_finish) state_d = LSU_B;
      LSU_B:    if (b_fire) state_d = LSU_RESP;
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  assign aw_done_d = (state_q == LSU_AWW) && !aww_finish && (aw_done_q || aw_fire);
  assign w_done_d  = (state_q == LSU_AWW) && !aww_finish && (w_done_q || w_fire);

  ysyx_23060236_Reg #(.WIDTH(3), .RESET_VAL(LSU_IDLE)) u_state_reg (
    .clock(clock), .reset(reset), .din(state_d), .wen(1'b1), .dout(state_q));
  ysyx_23060236_Reg #(.WIDTH(1)) u_aw_done_reg (
    .clock(clock), .reset(reset), .din(aw_done_d), .wen(1'b1), .dout(aw_done_q));
  ysyx_23060236_Reg #(.WIDTH(1)) u_w_done_reg (
    .clock(clock), .reset(reset), .din(w_done_d), .wen(1'b1), .dout(w_done_q));

  ysyx_23060236_Reg #(.WIDTH(32)) u_addr_reg (
    .clock(clock), .reset(reset), .din(req_addr), .wen(accept), .dout(addr_q));
  ysyx_23060236_Reg #(.WIDTH(3)) u_funct3_reg (
    .clock(clock), .reset(reset), .din(req_funct3), .wen(accept), .dout(funct3_q));
  ysyx_23060236_Reg #(.WIDTH(1)) u_wen_reg (
    .clock(clock), .reset(reset), .din(req_wen), .wen(accept), .dout(wen_q));
  ysyx_23060236_Reg #(.WIDTH(32)) u_wdata_reg (
    .clock(clock), .reset(reset), .din(req_wdata), .wen(accept), .dout(wdata_q));

  // Load data only ever changes on a load completion; stores leave it alone.
  assign rdata_wen = (state_q == LSU_R) && r_fire && !wen_q;

  ysyx_23060236_Reg #(.WIDTH(32)) u_rdata_reg (
    .clock(clock), .reset(reset), .din(rdata_ext), .wen(rdata_wen), .dout(rdata_q));

  // Bus errors are captured on completion; a misaligned accept clears the
  // stored flag and its error is reported from the latched request in RESP.
  always_comb begin
    err_d   = 1'b0;
    err_wen = accept;
    if (state_q == LSU_R && r_fire) begin
      err_d   = (lsu_rresp != AXI_RESP_OKAY);
      err_wen = 1'b1;
    end else if (state_q == LSU_B && b_fire) begin
      err_d   = (lsu_bresp != AXI_RESP_OKAY);
      err_wen = 1'b1;
    end
  end

  ysyx_23060236_Reg #(.WIDTH(1)) u_err_reg (
    .clock(clock), .reset(reset), .din(err_d), .wen(err_wen), .dout(err_q));

  assign req_ready  = (state_q == LSU_IDLE);
  assign resp_valid = (state_q == LSU_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q || (resp_valid && latched_misaligned);

  assign lsu_araddr  = addr_q;
  assign lsu_arsize  = {1'b0, funct3_q[1:0]};
  assign lsu_arvalid = (state_q == LSU_AR);
  assign lsu_rready  = (state_q == LSU_R);

  assign lsu_awaddr  = addr_q;
  assign lsu_awsize  = {1'b0, funct3_q[1:0]};
  assign lsu_awvalid = (state_q == LSU_AWW) && !aw_done_q;
  assign lsu_wvalid  = (state_q == LSU_AWW) && !w_done_q;
  assign lsu_wdata   = wdata_lanes;
  // Strobes are forced low outside a write so idle/reset shows no active lanes.
  assign lsu_wstrb   = (state_q == LSU_AWW) ? strb_lanes : 4'b0000;
  assign lsu_bready  = (state_q == LSU_B);

endmodule

// File: tb/tb_ysyx_23060236_lsu.sv
// tb_ysyx_23060236_lsu
// Directed self-checking bench for the LSU: reset state, load extraction,
// store lane placement with a slow slave, misalignment, bus errors and
// reset in the middle of a read.
module tb_ysyx_23060236_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [2:0]  lsu_arsize, lsu_awsize;
  logic [1:0]  lsu_rresp, lsu_bresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
  logic [3:0]  lsu_wstrb;
  logic        lsu_bvalid, lsu_bready;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  ysyx_23060236_lsu dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arsize(lsu_arsize),
    .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awsize(lsu_awsize),
    .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] funct3);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = funct3;
  endtask

  // Returns the cycle (counted from the accept edge) at which resp_valid
  // was seen, or -1 if it never came within the budget.
  task automatic wait_resp(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) req_valid = 1'b0;
      if (resp_valid) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    compared++;
    if ({req_ready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready,
         resp_valid, resp_err} !== 8'b1000_0000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected %b",
               {req_ready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready,
                resp_valid, resp_err}, 8'b1000_0000);
    end
    compared++;
    if ({lsu_araddr, lsu_awaddr, lsu_wdata, resp_rdata} !== 128'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_addr_data: got %h %h %h %h expected all 0",
               lsu_araddr, lsu_awaddr, lsu_wdata, resp_rdata);
    end
    compared++;
    if ({lsu_wstrb, lsu_arsize, lsu_awsize} !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_strb_size: got %h %h %h expected 0 0 0",
               lsu_wstrb, lsu_arsize, lsu_awsize);
    end
    reset = 1'b0;
  endtask

  task automatic test_lb();
    lsu_arready = 1'b1; lsu_rvalid = 1'b1; lsu_rdata = 32'h80FF_1234; lsu_rresp = 2'b00;
    drive_req(1'b0, 32'h8000_0003, 32'h0, 3'b000);
    tick();
    req_valid = 1'b0;
    compared++;
    if ({lsu_arvalid, lsu_rready, resp_valid} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL lb_cycle1_flags: got %b expected 100",
               {lsu_arvalid, lsu_rready, resp_valid});
    end
    compared++;
    if (lsu_araddr !== 32'h8000_0003 || lsu_arsize !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL lb_araddr_size: got %h/%0d expected 80000003/0", lsu_araddr, lsu_arsize);
    end
    tick();
    compared++;
    if ({lsu_arvalid, lsu_rready, resp_valid} !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL lb_cycle2_flags: got %b expected 010",
               {lsu_arvalid, lsu_rready, resp_valid});
    end
    tick();
    compared++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80 || resp_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lb_resp: got v=%b d=%h e=%b expected v=1 d=ffffff80 e=0",
               resp_valid, resp_rdata, resp_err);
    end
    tick();
    compared++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL lb_back_idle: got v=%b rdy=%b expected v=0 rdy=1", resp_valid, req_ready);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] addrs [4] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0002};
    logic [2:0]  f3s   [4] = '{3'b101, 3'b001, 3'b100, 3'b000};
    logic [31:0] datas [4] = '{32'hBEEF_0000, 32'h0000_8001, 32'h0000_F000, 32'h0012_0000};
    logic [31:0] exps  [4] = '{32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_00F0, 32'h0000_0012};
    int cycles;
    for (int i = 0; i < 4; i++) begin
      lsu_arready = 1'b1; lsu_rvalid = 1'b1; lsu_rdata = datas[i]; lsu_rresp = 2'b00;
      drive_req(1'b0, addrs[i], 32'h0, f3s[i]);
      wait_resp(cycles);
      compared++;
      if (cycles !== 3 || resp_rdata !== exps[i] || resp_err !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL load_ext_%0d: got cyc=%0d d=%h e=%b expected cyc=3 d=%h e=0",
                 i, cycles, resp_rdata, resp_err, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_sb_slow_aw();
    lsu_awready = 1'b0; lsu_wready = 1'b1; lsu_bvalid = 1'b0; lsu_bresp = 2'b00;
    drive_req(1'b1, 32'hA000_0001, 32'h0000_00AB, 3'b000);
    tick();
    req_valid = 1'b0;
    compared++;
    if ({lsu_awvalid, lsu_wvalid} !== 2'b11 || lsu_wstrb !== 4'b0010 ||
        lsu_wdata !== 32'h0000_AB00 || lsu_awsize !== 3'd0 || lsu_awaddr !== 32'hA000_0001) begin
      mismatched++;
      $display("[TB] FAIL sb_cycle1: got v=%b strb=%b d=%h sz=%0d a=%h expected v=11 strb=0010 d=0000ab00 sz=0 a=a0000001",
               {lsu_awvalid, lsu_wvalid}, lsu_wstrb, lsu_wdata, lsu_awsize, lsu_awaddr);
    end
    tick();
    compared++;
    if ({lsu_awvalid, lsu_wvalid} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL sb_wvalid_drop: got %b expected 10", {lsu_awvalid, lsu_wvalid});
    end
    tick();
    compared++;
    if (lsu_awvalid !== 1'b1 || lsu_awaddr !== 32'hA000_0001 || lsu_bready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sb_aw_hold: got v=%b a=%h br=%b expected v=1 a=a0000001 br=0",
               lsu_awvalid, lsu_awaddr, lsu_bready);
    end
    lsu_awready = 1'b1;
    tick();
    lsu_awready = 1'b0;
    compared++;
    if ({lsu_awvalid, lsu_wvalid, lsu_bready} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL sb_in_b: got %b expected 001", {lsu_awvalid, lsu_wvalid, lsu_bready});
    end
    lsu_bvalid = 1'b1;
    tick();
    lsu_bvalid = 1'b0;
    compared++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0000_0012) begin
      mismatched++;
      $display("[TB] FAIL sb_resp: got v=%b e=%b d=%h expected v=1 e=0 d=00000012",
               resp_valid, resp_err, resp_rdata);
    end
    tick();
  endtask

  task automatic test_sh_lanes();
    int cycles;
    lsu_awready = 1'b1; lsu_wready = 1'b1; lsu_bvalid = 1'b1; lsu_bresp = 2'b00;
    drive_req(1'b1, 32'h8000_0006, 32'h1234_BEEF, 3'b001);
    tick();
    req_valid = 1'b0;
    compared++;
    if (lsu_wstrb !== 4'b1100 || lsu_wdata !== 32'hBEEF_0000 || lsu_awsize !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL sh_lanes: got strb=%b d=%h sz=%0d expected strb=1100 d=beef0000 sz=1",
               lsu_wstrb, lsu_wdata, lsu_awsize);
    end
    cycles = -1;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (resp_valid) begin
        cycles = i;
        break;
      end
    end
    compared++;
    if (cycles !== 3) begin
      mismatched++;
      $display("[TB] FAIL sh_latency: got %0d expected 3", cycles);
    end
    lsu_bvalid = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    int cycles;
    lsu_arready = 1'b1; lsu_rvalid = 1'b1; lsu_rresp = 2'b00;
    drive_req(1'b0, 32'h8000_0002, 32'h0, 3'b010);
    tick();
    req_valid = 1'b0;
    compared++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || lsu_arvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lw_misaligned: got v=%b e=%b ar=%b expected v=1 e=1 ar=0",
               resp_valid, resp_err, lsu_arvalid);
    end
    tick();
    compared++;
    if (lsu_arvalid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lw_misaligned_after: got ar=%b rdy=%b v=%b expected 0 1 0",
               lsu_arvalid, req_ready, resp_valid);
    end
    drive_req(1'b1, 32'h8000_0001, 32'h0, 3'b001);
    wait_resp(cycles);
    compared++;
    if (cycles !== 1 || resp_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sh_misaligned: got cyc=%0d e=%b expected cyc=1 e=1", cycles, resp_err);
    end
    tick();
  endtask

  task automatic test_bus_errors();
    int cycles;
    lsu_awready = 1'b1; lsu_wready = 1'b1; lsu_bvalid = 1'b1; lsu_bresp = 2'b10;
    drive_req(1'b1, 32'h8000_0010, 32'h1234_5678, 3'b010);
    wait_resp(cycles);
    compared++;
    if (cycles !== 3 || resp_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sw_bresp_err: got cyc=%0d e=%b expected cyc=3 e=1", cycles, resp_err);
    end
    tick();
    lsu_bvalid = 1'b0; lsu_bresp = 2'b00;
    lsu_arready = 1'b1; lsu_rvalid = 1'b1; lsu_rdata = 32'hDEAD_BEEF; lsu_rresp = 2'b11;
    drive_req(1'b0, 32'h8000_0020, 32'h0, 3'b010);
    wait_resp(cycles);
    compared++;
    if (cycles !== 3 || resp_err !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("[TB] FAIL lw_rresp_err: got cyc=%0d e=%b d=%h expected cyc=3 e=1 d=deadbeef",
               cycles, resp_err, resp_rdata);
    end
    tick();
    lsu_rresp = 2'b00; lsu_rdata = 32'hCAFE_F00D;
    drive_req(1'b0, 32'h8000_0024, 32'h0, 3'b010);
    wait_resp(cycles);
    compared++;
    if (cycles !== 3 || resp_err !== 1'b0 || resp_rdata !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("[TB] FAIL lw_clean: got cyc=%0d e=%b d=%h expected cyc=3 e=0 d=cafef00d",
               cycles, resp_err, resp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cycles;
    lsu_arready = 1'b1; lsu_rvalid = 1'b0; lsu_rresp = 2'b00;
    drive_req(1'b0, 32'h8000_0000, 32'h0, 3'b010);
    tick();
    req_valid = 1'b0;
    tick();
    compared++;
    if (lsu_rready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_in_r: got rready=%b expected 1", lsu_rready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if ({lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready, resp_valid, req_ready}
        !== 7'b000_0001) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_flags: got %b expected 0000001",
               {lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready, resp_valid, req_ready});
    end
    lsu_rvalid = 1'b1; lsu_rdata = 32'h1122_3344;
    drive_req(1'b0, 32'h8000_0000, 32'h0, 3'b010);
    wait_resp(cycles);
    compared++;
    if (cycles !== 3 || resp_rdata !== 32'h1122_3344 || resp_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_recover: got cyc=%0d d=%h e=%b expected cyc=3 d=11223344 e=0",
               cycles, resp_rdata, resp_err);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    lsu_arready = 1'b0; lsu_rdata = '0; lsu_rresp = '0; lsu_rvalid = 1'b0;
    lsu_awready = 1'b0; lsu_wready = 1'b0; lsu_bresp = '0; lsu_bvalid = 1'b0;

    test_reset();
    test_lb();
    test_load_ext();
    test_sb_slow_aw();
    test_sh_lanes();
    test_misaligned();
    test_bus_errors();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
